// File: rtl/lht_spec_history_table.sv
`default_nettype none
// ============================================================================
// Module   : lht_spec_history_table
// Purpose  : Local branch history table, speculative + committed copies with
//            a sequential flush-repair walk.
// Revision : 1.0
// ============================================================================
module lht_spec_history_table #(
    parameter int ENTRIES      = 32,
    parameter int HIST_W       = 5,
    parameter int SHIFT_IN_MSB = 1,
    localparam int IDX_W       = $clog2(ENTRIES)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [IDX_W-1:0]  lkp_idx,
    output logic [HIST_W-1:0] lkp_hist,
    output logic              lkp_ready,
    input  logic              spec_upd_en,
    input  logic [IDX_W-1:0]  spec_upd_idx,
    input  logic              spec_upd_dir,
    input  logic              cmt_upd_en,
    input  logic [IDX_W-1:0]  cmt_upd_idx,
    input  logic              cmt_upd_dir,
    input  logic              flush,
    output logic              restore_busy
);

    typedef enum logic [0:0] {
        ST_IDLE    = 1'b0,
        ST_RESTORE = 1'b1
    } state_t;

    localparam logic [IDX_W-1:0] c_LAST_IDX = IDX_W'(ENTRIES - 1);

    state_t            state_q, state_d;
    logic [IDX_W-1:0]  rc_q, rc_d;
    logic [HIST_W-1:0] spec_q [ENTRIES];
    logic [HIST_W-1:0] spec_d [ENTRIES];
    logic [HIST_W-1:0] cmt_q  [ENTRIES];
    logic [HIST_W-1:0] cmt_d  [ENTRIES];

    function automatic logic [HIST_W-1:0] shift_hist(input logic [HIST_W-1:0] h,
                                                     input logic              d);
        if (SHIFT_IN_MSB != 0) begin
            return {d, h[HIST_W-1:1]};
        end else begin
            return {h[HIST_W-2:0], d};
        end
    endfunction

    always_comb begin
        cmt_d   = cmt_q;
        spec_d  = spec_q;
        state_d = state_q;
        rc_d    = rc_q;

        if (cmt_upd_en) begin
            cmt_d[cmt_upd_idx] = shift_hist(cmt_q[cmt_upd_idx], cmt_upd_dir);
        end

        case (state_q)
            ST_IDLE: begin
                if (flush) begin
                    state_d = ST_RESTORE;
                    rc_d    = '0;
                end else if (spec_upd_en) begin
                    spec_d[spec_upd_idx] = shift_hist(spec_q[spec_upd_idx], spec_upd_dir);
                end
            end
            ST_RESTORE: begin
                // Copy the post-commit value so a same-cycle commit is not lost.
                if (flush) begin
                    rc_d = '0;
                end else begin
                    spec_d[rc_q] = cmt_d[rc_q];
                    rc_d         = rc_q + IDX_W'(1);
                    if (rc_q == c_LAST_IDX) begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                rc_d    = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            rc_q    <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                spec_q[i] <= '0;
                cmt_q[i]  <= '0;
            end
        end else begin
            state_q <= state_d;
            rc_q    <= rc_d;
            spec_q  <= spec_d;
            cmt_q   <= cmt_d;
        end
    end

    assign lkp_hist     = spec_q[lkp_idx];
    assign restore_busy = (state_q == ST_RESTORE);
    assign lkp_ready    = (state_q != ST_RESTORE);

endmodule
`default_nettype wire

// File: tb/tb_lht_spec_history_table.sv
`default_nettype none
// ============================================================================
// Module   : tb_lht_spec_history_table
// Purpose  : Scoreboard bench for lht_spec_history_table (both shift modes).
// Revision : 1.0
// ============================================================================
module tb_lht_spec_history_table;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [4:0] lkp_idx = '0;
    logic [4:0] lkp_hist, lkp_hist0;
    logic       lkp_ready, lkp_ready0;
    logic       spec_upd_en = 1'b0;
    logic [4:0] spec_upd_idx = '0;
    logic       spec_upd_dir = 1'b0;
    logic       cmt_upd_en = 1'b0;
    logic [4:0] cmt_upd_idx = '0;
    logic       cmt_upd_dir = 1'b0;
    logic       flush = 1'b0;
    logic       restore_busy, restore_busy0;

    int checks   = 0;
    int failures = 0;

    logic [4:0] m_spec [32];
    logic [4:0] m_cmt  [32];
    logic       m_busy;
    logic [4:0] m_rc;
    logic [4:0] exp_q [$];
    logic [4:0] exp_v;

    always #5 clk = ~clk;

    lht_spec_history_table #(.ENTRIES(32), .HIST_W(5), .SHIFT_IN_MSB(1)) dut (
        .clk(clk), .rst(rst), .lkp_idx(lkp_idx), .lkp_hist(lkp_hist), .lkp_ready(lkp_ready),
        .spec_upd_en(spec_upd_en), .spec_upd_idx(spec_upd_idx), .spec_upd_dir(spec_upd_dir),
        .cmt_upd_en(cmt_upd_en), .cmt_upd_idx(cmt_upd_idx), .cmt_upd_dir(cmt_upd_dir),
        .flush(flush), .restore_busy(restore_busy)
    );

    lht_spec_history_table #(.ENTRIES(32), .HIST_W(5), .SHIFT_IN_MSB(0)) dut0 (
        .clk(clk), .rst(rst), .lkp_idx(lkp_idx), .lkp_hist(lkp_hist0), .lkp_ready(lkp_ready0),
        .spec_upd_en(spec_upd_en), .spec_upd_idx(spec_upd_idx), .spec_upd_dir(spec_upd_dir),
        .cmt_upd_en(cmt_upd_en), .cmt_upd_idx(cmt_upd_idx), .cmt_upd_dir(cmt_upd_dir),
        .flush(flush), .restore_busy(restore_busy0)
    );

    function automatic logic [4:0] sh(input logic [4:0] h, input logic d);
        return {d, h[4:1]};
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 32; i++) begin
            m_spec[i] = '0;
            m_cmt[i]  = '0;
        end
        m_busy = 1'b0;
        m_rc   = '0;
    endtask

    // Advance one clock; the reference model consumes the inputs seen at the edge.
    task automatic cycle();
        logic [4:0] cn [32];
        @(posedge clk);
        if (rst) begin
            model_clear();
        end else begin
            cn = m_cmt;
            if (cmt_upd_en) cn[cmt_upd_idx] = sh(m_cmt[cmt_upd_idx], cmt_upd_dir);
            if (!m_busy) begin
                if (flush) begin
                    m_busy = 1'b1;
                    m_rc   = '0;
                end else if (spec_upd_en) begin
                    m_spec[spec_upd_idx] = sh(m_spec[spec_upd_idx], spec_upd_dir);
                end
            end else if (flush) begin
                m_rc = '0;
            end else begin
                m_spec[m_rc] = cn[m_rc];
                if (m_rc == 5'd31) m_busy = 1'b0;
                m_rc = m_rc + 5'd1;
            end
            m_cmt = cn;
        end
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        model_clear();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        checks++;
        if (lkp_ready !== 1'b1 || restore_busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_flags ready=%b busy=%b required ready=1 busy=0", lkp_ready, restore_busy);
        end
        for (int i = 0; i < 32; i++) begin
            exp_q.push_back(5'd0);
            lkp_idx = 5'(i);
            #1;
            exp_v = exp_q.pop_front();
            checks++;
            if (lkp_hist !== exp_v) begin
                failures++;
                $display("FAIL reset_lookup idx=%0d got=%b required=%b", i, lkp_hist, exp_v);
            end
        end
    endtask

    task automatic test_shift();
        logic [2:0]  dirs;
        logic [14:0] exp_msb;
        logic [14:0] exp_lsb;
        dirs    = 3'b101;
        exp_msb = {5'b10000, 5'b01000, 5'b10100};
        exp_lsb = {5'b00001, 5'b00010, 5'b00101};
        spec_upd_en  = 1'b1;
        spec_upd_idx = 5'd3;
        lkp_idx      = 5'd3;
        for (int k = 0; k < 3; k++) begin
            spec_upd_dir = dirs[2-k];
            exp_q.push_back(exp_msb[14-5*k -: 5]);
            exp_q.push_back(exp_lsb[14-5*k -: 5]);
            cycle();
            exp_v = exp_q.pop_front();
            checks++;
            if (lkp_hist !== exp_v) begin
                failures++;
                $display("FAIL shift_msb step=%0d got=%b required=%b", k, lkp_hist, exp_v);
            end
            exp_v = exp_q.pop_front();
            checks++;
            if (lkp_hist0 !== exp_v) begin
                failures++;
                $display("FAIL shift_lsb step=%0d got=%b required=%b", k, lkp_hist0, exp_v);
            end
        end
        spec_upd_en = 1'b0;
    endtask

    task automatic test_restore();
        int n;
        logic [2:0] sdirs;
        sdirs = 3'b001;
        spec_upd_idx = 5'd7;
        cmt_upd_idx  = 5'd7;
        for (int k = 0; k < 3; k++) begin
            spec_upd_en  = 1'b1;
            spec_upd_dir = sdirs[2-k];
            cmt_upd_en   = (k < 2);
            cmt_upd_dir  = 1'b1;
            cycle();
        end
        spec_upd_en = 1'b0;
        cmt_upd_en  = 1'b1;
        cmt_upd_idx = 5'd12;
        cmt_upd_dir = 1'b1;
        cycle();
        cmt_upd_en  = 1'b0;
        lkp_idx = 5'd7;
        exp_q.push_back(5'b10000);
        #1;
        exp_v = exp_q.pop_front();
        checks++;
        if (lkp_hist !== exp_v) begin
            failures++;
            $display("FAIL prewalk_spec7 got=%b required=%b", lkp_hist, exp_v);
        end
        flush = 1'b1;
        cycle();
        flush = 1'b0;
        n = 0;
        while (restore_busy === 1'b1 && n < 100) begin
            if (lkp_ready !== 1'b0) begin
                checks++;
                failures++;
                $display("FAIL walk_ready cycle=%0d got=%b required=0", n, lkp_ready);
            end
            spec_upd_en  = 1'b1;
            spec_upd_idx = 5'($urandom_range(0, 31));
            spec_upd_dir = 1'($urandom_range(0, 1));
            cycle();
            n++;
        end
        spec_upd_en = 1'b0;
        checks++;
        if (n != 32) begin
            failures++;
            $display("FAIL walk_length got=%0d required=32", n);
        end
        exp_q.push_back(5'b11000);
        lkp_idx = 5'd7;
        #1;
        exp_v = exp_q.pop_front();
        checks++;
        if (lkp_hist !== exp_v) begin
            failures++;
            $display("FAIL restored_spec7 got=%b required=%b", lkp_hist, exp_v);
        end
        for (int i = 0; i < 32; i++) begin
            exp_q.push_back(m_cmt[i]);
            lkp_idx = 5'(i);
            #1;
            exp_v = exp_q.pop_front();
            checks++;
            if (lkp_hist !== exp_v) begin
                failures++;
                $display("FAIL restored_entry idx=%0d got=%b required=%b", i, lkp_hist, exp_v);
            end
        end
    endtask

    task automatic test_commit_during_walk();
        int n;
        logic [4:0] exp20, exp5;
        exp20 = '0;
        exp5  = '0;
        flush = 1'b1;
        cycle();
        flush = 1'b0;
        n = 0;
        while (restore_busy === 1'b1 && n < 100) begin
            cmt_upd_en = 1'b0;
            if (m_rc == 5'd20) begin
                cmt_upd_en  = 1'b1;
                cmt_upd_idx = 5'd20;
                cmt_upd_dir = 1'b1;
                exp20 = sh(m_cmt[20], 1'b1);
            end else if (m_rc == 5'd25) begin
                cmt_upd_en  = 1'b1;
                cmt_upd_idx = 5'd5;
                cmt_upd_dir = 1'b1;
                exp5 = m_cmt[5];
            end
            cycle();
            n++;
        end
        cmt_upd_en = 1'b0;
        checks++;
        if (n != 32) begin
            failures++;
            $display("FAIL walk2_length got=%0d required=32", n);
        end
        exp_q.push_back(exp20);
        exp_q.push_back(exp5);
        lkp_idx = 5'd20;
        #1;
        exp_v = exp_q.pop_front();
        checks++;
        if (lkp_hist !== exp_v) begin
            failures++;
            $display("FAIL same_cycle_commit_idx20 got=%b required=%b", lkp_hist, exp_v);
        end
        lkp_idx = 5'd5;
        #1;
        exp_v = exp_q.pop_front();
        checks++;
        if (lkp_hist !== exp_v) begin
            failures++;
            $display("FAIL no_recopy_idx5 got=%b required=%b", lkp_hist, exp_v);
        end
    endtask

    task automatic test_same_idx();
        logic [4:0] exp_s;
        spec_upd_en  = 1'b1;
        spec_upd_idx = 5'd9;
        spec_upd_dir = 1'b1;
        cmt_upd_en   = 1'b1;
        cmt_upd_idx  = 5'd9;
        cmt_upd_dir  = 1'b0;
        exp_s = sh(m_spec[9], 1'b1);
        exp_q.push_back(exp_s);
        cycle();
        spec_upd_en = 1'b0;
        cmt_upd_en  = 1'b0;
        lkp_idx = 5'd9;
        #1;
        exp_v = exp_q.pop_front();
        checks++;
        if (lkp_hist !== exp_v) begin
            failures++;
            $display("FAIL same_idx_spec got=%b required=%b", lkp_hist, exp_v);
        end
        // Diverge several speculative entries so the next repair has work to do.
        for (int k = 0; k < 6; k++) begin
            spec_upd_en  = 1'b1;
            spec_upd_idx = 5'(k * 5);
            spec_upd_dir = 1'b1;
            cycle();
        end
        spec_upd_en = 1'b0;
    endtask

    task automatic test_flush_restart();
        int n;
        flush = 1'b1;
        cycle();
        flush = 1'b0;
        n = 0;
        while (m_rc != 5'd10 && n < 100) begin
            cycle();
            n++;
        end
        flush = 1'b1;
        cycle();
        flush = 1'b0;
        checks++;
        if (restore_busy !== 1'b1) begin
            failures++;
            $display("FAIL restart_busy got=%b required=1", restore_busy);
        end
        n = 0;
        while (restore_busy === 1'b1 && n < 100) begin
            cycle();
            n++;
        end
        checks++;
        if (n != 32) begin
            failures++;
            $display("FAIL restart_length got=%0d required=32", n);
        end
        for (int i = 0; i < 32; i++) begin
            exp_q.push_back(m_cmt[i]);
            lkp_idx = 5'(i);
            #1;
            exp_v = exp_q.pop_front();
            checks++;
            if (lkp_hist !== exp_v) begin
                failures++;
                $display("FAIL restart_entry idx=%0d got=%b required=%b", i, lkp_hist, exp_v);
            end
        end
    endtask

    task automatic test_reset_mid_walk();
        int n;
        spec_upd_en  = 1'b1;
        spec_upd_idx = 5'd2;
        spec_upd_dir = 1'b1;
        cycle();
        spec_upd_en = 1'b0;
        flush = 1'b1;
        cycle();
        flush = 1'b0;
        n = 0;
        while (m_rc != 5'd15 && n < 100) begin
            cycle();
            n++;
        end
        #2;
        rst = 1'b1;
        model_clear();
        #1;
        checks++;
        if (restore_busy !== 1'b0 || lkp_ready !== 1'b1) begin
            failures++;
            $display("FAIL async_reset_flags busy=%b ready=%b required busy=0 ready=1", restore_busy, lkp_ready);
        end
        for (int i = 0; i < 32; i++) begin
            exp_q.push_back(m_spec[i]);
            lkp_idx = 5'(i);
            #0.25;
            exp_v = exp_q.pop_front();
            checks++;
            if (lkp_hist !== exp_v) begin
                failures++;
                $display("FAIL async_reset_lookup idx=%0d got=%b required=%b", i, lkp_hist, exp_v);
            end
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        cycle();
        checks++;
        if (restore_busy !== 1'b0) begin
            failures++;
            $display("FAIL post_reset_busy got=%b required=0", restore_busy);
        end
    endtask

    initial begin
        model_clear();
        test_reset();
        test_shift();
        test_restore();
        test_commit_during_walk();
        test_same_idx();
        test_flush_restart();
        test_reset_mid_walk();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/lht_spec_history_table.md
Name: lht_spec_history_table

Overview:
- Parametrised local branch history table with separate speculative and committed histories per entry.
- The fetch stage reads and speculatively shifts per-branch history. The commit stage shifts the architectural history.
- A pipeline flush starts a sequential repair walk that copies committed histories back into the speculative table.
- Sits between the fetch PC-index logic and the local pattern table (LPT). Replaces the fixed 32x5 non-speculative table.

Parameters:
- ENTRIES, 32, number of history entries; power of two, >= 2.
- HIST_W, 5, history bits per entry; >= 2.
- SHIFT_IN_MSB, 1, 1: new outcome enters at MSB and shifts right; 0: enters at LSB and shifts left.
- IDX_W, $clog2(ENTRIES), localparam; index width.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous reset, active-high.
- lkp_idx  in  IDX_W  lookup index from fetch.
- lkp_hist  out  HIST_W  speculative history at lkp_idx; combinational, pre-update value.
- lkp_ready  out  1  lookup/speculative port usable; equals !restore_busy.
- spec_upd_en  in  1  shift speculative entry.
- spec_upd_idx  in  IDX_W  speculative entry index.
- spec_upd_dir  in  1  predicted direction, 1 = taken.
- cmt_upd_en  in  1  shift committed entry.
- cmt_upd_idx  in  IDX_W  committed entry index.
- cmt_upd_dir  in  1  resolved direction.
- flush  in  1  misprediction/flush request; starts repair.
- restore_busy  out  1  repair walk in progress.

Behaviour:
- Reset (async, rst=1): all spec[] and cmt[] entries = 0, state IDLE, repair counter = 0, restore_busy = 0, lkp_ready = 1. lkp_hist = 0 for any index.
- Shift function sh(h,d):
  - SHIFT_IN_MSB=1: {d, h[HIST_W-1:1]}.
  - SHIFT_IN_MSB=0: {h[HIST_W-2:0], d}.
- Lookup: lkp_hist = spec[lkp_idx], zero latency. There is no bypass of same-cycle writes; the updated value is visible the next cycle.
- States: IDLE and RESTORE. The repair counter rc is IDX_W bits.
- IDLE:
  - spec_upd_en=1 -> spec[spec_upd_idx] <= sh(spec[spec_upd_idx], spec_upd_dir) at next edge.
  - flush=1 -> go to RESTORE, rc <= 0, restore_busy <= 1. A spec update in the same cycle is dropped (flush wins).
- RESTORE, each cycle:
  - spec[rc] <= cmt_next[rc], where cmt_next is the committed value including any commit update in that same cycle.
  - rc increments. After writing rc = ENTRIES-1, go to IDLE and drop restore_busy at the same edge.
  - Repair takes exactly ENTRIES cycles after the flush cycle.
- Commit updates: accepted in every state, every cycle. cmt[cmt_upd_idx] <= sh(cmt[cmt_upd_idx], cmt_upd_dir).
  - An entry already repaired, then committed again during the walk, is not re-copied. The commit stage only commits branches older than the flush, so this is legal.
- Flush during RESTORE restarts the walk: rc <= 0, and the entry at rc is not written that cycle. restore_busy stays 1.
- During RESTORE: spec_upd_en is ignored and lkp_hist still shows spec[lkp_idx] (partially repaired). Consumers must qualify with lkp_ready.
- spec_upd_idx == cmt_upd_idx in IDLE: the two tables are independent and both updates apply.
- Async reset mid-walk: immediately returns to IDLE with all tables cleared.
- lkp_idx, spec_upd_idx and cmt_upd_idx are always in range because ENTRIES is a power of two.

Test Plan:
- Reset, then lookup idx 0..31 -> lkp_hist=0, lkp_ready=1, restore_busy=0.
- SHIFT_IN_MSB=1, HIST_W=5: spec updates at idx 3 with dirs 1,0,1 on consecutive cycles -> lkp_hist(3) = 10000, 01000, 10100. With SHIFT_IN_MSB=0 the same sequence gives 00001, 00010, 00101.
- Commit idx 7 dirs 1,1 (cmt=11000). Spec idx 7 dirs 0,0,1 (spec=10000). Flush -> restore_busy=1 for exactly 32 cycles and lkp_ready=0. spec_upd_en during the walk has no effect. After the walk, lkp_hist(7)=11000 and every other entry = its committed value.
- Commit idx 20 dir 1 in the same cycle that rc=20 -> spec[20] = sh(old cmt[20],1) after repair.
- Flush again at rc=10 -> walk restarts: restore_busy remains 1 for 32 further cycles, and all entries end equal to committed.
- Assert rst mid-walk (rc=15) -> restore_busy=0 immediately and all lookups = 0.
